// File: rtl/bolo_scan_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : bolo_scan_sequencer_if
// Purpose  : Pixel sample stream between the scan sequencer and the capture
//            FIFO: sample word, row/column address, valid/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
interface bolo_scan_sequencer_if #(
  parameter int ROW_W  = 2,
  parameter int COL_W  = 2,
  parameter int DATA_W = 12
);
  logic [ROW_W-1:0]  row_o;
  logic [COL_W-1:0]  col_o;
  logic [DATA_W-1:0] sample_o;
  logic              sample_valid_o;
  logic              sample_ready_i;

  // Sequencer side drives the sample and its address
  modport master (
    output row_o,
    output col_o,
    output sample_o,
    output sample_valid_o,
    input  sample_ready_i
  );

  // Capture FIFO side accepts samples
  modport slave (
    input  row_o,
    input  col_o,
    input  sample_o,
    input  sample_valid_o,
    output sample_ready_i
  );
endinterface
`default_nettype wire

// File: rtl/bolo_scan_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : bolo_scan_sequencer
// Purpose  : ROWS x COLS bolometer matrix scan controller. For every row it
//            writes the bias DAC, waits a settling time, optionally throws
//            away one ADC conversion, then converts and streams each pixel.
// Revision : 1.0 - initial release
// ============================================================================
module bolo_scan_sequencer #(
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int ROW_W      = 2,
  parameter int COL_W      = 2,
  parameter int SETTLE_CYC = 1000,
  parameter int DUMMY_EN   = 1,
  parameter int DATA_W     = 12
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic                  abort_i,
  input  logic [7:0]            nframes_i,
  output logic                  stdac_o,
  input  logic                  eodac_i,
  output logic                  stadc_o,
  input  logic                  eoadc_i,
  input  logic [DATA_W-1:0]     adc_data_i,
  output logic                  frame_done_o,
  output logic                  busy_o,
  output logic                  eos_o,
  bolo_scan_sequencer_if.master sample_if
);

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_ROW_DAC  = 4'd1;
  localparam logic [3:0] S_DAC_WT   = 4'd2;
  localparam logic [3:0] S_SETTLE   = 4'd3;
  localparam logic [3:0] S_DUMMY_ST = 4'd4;
  localparam logic [3:0] S_DUMMY_WT = 4'd5;
  localparam logic [3:0] S_ADC_ST   = 4'd6;
  localparam logic [3:0] S_ADC_WT   = 4'd7;
  localparam logic [3:0] S_OUT      = 4'd8;
  localparam logic [3:0] S_ADVANCE  = 4'd9;

  localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  logic [3:0]        state;
  logic [3:0]        state_nxt;
  logic [ROW_W-1:0]  row_cnt;
  logic [COL_W-1:0]  col_cnt;
  logic [7:0]        frame_cnt;
  logic [7:0]        nframes_q;
  logic [SET_W-1:0]  settle_cnt;
  logic [DATA_W-1:0] sample_q;
  logic              abort_pend;
  logic              sample_valid;

  logic abort_now;
  logic last_col;
  logic last_row;
  logic settle_done;
  logic last_frame;
  logic [7:0] frame_inc;

  // An abort seen this cycle is honoured at once, as if it were already pending
  assign abort_now   = abort_pend | abort_i;
  assign last_col    = (col_cnt == COL_W'(COLS - 1));
  assign last_row    = (row_cnt == ROW_W'(ROWS - 1));
  assign settle_done = (settle_cnt == SET_W'(SETTLE_CYC - 1));
  assign frame_inc   = frame_cnt + 8'd1;
  // nframes of zero means run forever, so the frame count never terminates it
  assign last_frame  = (nframes_q != 8'd0) && (frame_inc == nframes_q);

  assign sample_if.row_o          = row_cnt;
  assign sample_if.col_o          = col_cnt;
  assign sample_if.sample_o       = sample_q;
  assign sample_if.sample_valid_o = sample_valid;

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: every wait state only leaves on its own done pulse
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:     if (start_i) state_nxt = S_ROW_DAC;
      S_ROW_DAC:  state_nxt = abort_now ? S_IDLE : S_DAC_WT;
      S_DAC_WT:   if (eodac_i) state_nxt = abort_now ? S_IDLE : S_SETTLE;
      S_SETTLE: begin
        if (abort_now) begin
          state_nxt = S_IDLE;
        end else if (settle_done) begin
          state_nxt = (DUMMY_EN != 0) ? S_DUMMY_ST : S_ADC_ST;
        end
      end
      S_DUMMY_ST: state_nxt = abort_now ? S_IDLE : S_DUMMY_WT;
      S_DUMMY_WT: if (eoadc_i) state_nxt = abort_now ? S_IDLE : S_ADC_ST;
      S_ADC_ST:   state_nxt = abort_now ? S_IDLE : S_ADC_WT;
      S_ADC_WT:   if (eoadc_i) state_nxt = abort_now ? S_IDLE : S_OUT;
      S_OUT:      if (sample_if.sample_ready_i) state_nxt = abort_now ? S_IDLE : S_ADVANCE;
      S_ADVANCE: begin
        if (abort_now) begin
          state_nxt = S_IDLE;
        end else if (!last_col) begin
          state_nxt = S_ADC_ST;
        end else if (!last_row) begin
          state_nxt = S_ROW_DAC;
        end else begin
          state_nxt = last_frame ? S_IDLE : S_ROW_DAC;
        end
      end
      default:    state_nxt = S_IDLE;
    endcase
  end

  // Output decode: strobes are single-cycle because their states last one cycle
  always_comb begin
    stdac_o      = 1'b0;
    stadc_o      = 1'b0;
    sample_valid = 1'b0;
    frame_done_o = 1'b0;
    busy_o       = 1'b1;
    eos_o        = 1'b0;
    case (state)
      S_IDLE: begin
        busy_o = 1'b0;
        eos_o  = 1'b1;
      end
      S_ROW_DAC:  stdac_o = 1'b1;
      S_DUMMY_ST: stadc_o = 1'b1;
      S_ADC_ST:   stadc_o = 1'b1;
      S_OUT:      sample_valid = 1'b1;
      S_ADVANCE:  frame_done_o = last_col & last_row & ~abort_now;
      default: begin
        stdac_o = 1'b0;
      end
    endcase
  end

  // Abort request latch, dropped once the sequencer is back in IDLE
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      abort_pend <= 1'b0;
    end else if (state == S_IDLE) begin
      abort_pend <= 1'b0;
    end else if (abort_i) begin
      abort_pend <= 1'b1;
    end
  end

  // Settle timer runs only while in SETTLE and restarts from zero on entry
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      settle_cnt <= '0;
    end else if (state == S_SETTLE) begin
      settle_cnt <= settle_cnt + 1'b1;
    end else begin
      settle_cnt <= '0;
    end
  end

  // Sample capture; an aborted conversion leaves the previous sample in place
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sample_q <= '0;
    end else if ((state == S_ADC_WT) && eoadc_i && !abort_now) begin
      sample_q <= adc_data_i;
    end
  end

  // Pixel address and frame counters
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      row_cnt   <= '0;
      col_cnt   <= '0;
      frame_cnt <= 8'd0;
      nframes_q <= 8'd0;
    end else if ((state == S_IDLE) && start_i) begin
      row_cnt   <= '0;
      col_cnt   <= '0;
      frame_cnt <= 8'd0;
      nframes_q <= nframes_i;
    end else if ((state == S_ADVANCE) && !abort_now) begin
      if (!last_col) begin
        col_cnt <= col_cnt + 1'b1;
      end else begin
        col_cnt <= '0;
        if (!last_row) begin
          row_cnt <= row_cnt + 1'b1;
        end else begin
          row_cnt   <= '0;
          frame_cnt <= frame_inc;
        end
      end
    end
  end

endmodule
`default_nettype wire
